// File: rtl/nearest_neighbor_compute_ctrl.sv
// nearest_neighbor_compute_ctrl
//
// Schedules the up-sample compute stage. Walks the output raster (y outer,
// x inner), issues reads to hw_input_stencil_ub with output coordinates and
// forwards each returned pixel as a write into nearest_neighbor_stencil_ub
// at the same coordinates, READ_LATENCY non-stalled cycles later.
//
// The compile-time macro NN_CTRL_PROTOCOL_CHECK_EN enables the sticky
// protocol error flag and a simulation assertion on read coordinates.
// Without it, err is tied low and no checking logic is built.

module nearest_neighbor_compute_ctrl #(
    parameter int OUT_W        = 128,
    parameter int OUT_H        = 128,
    parameter int READ_LATENCY = 1,
    parameter int DW           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_ren,
    output logic [2:0][DW-1:0]   rd_ctrl_vars,
    input  logic [DW-1:0]        rd_data,
    output logic                 wr_wen,
    output logic [2:0][DW-1:0]   wr_ctrl_vars,
    output logic [DW-1:0]        wr_data,
    output logic                 err
);

    localparam int            LAST   = READ_LATENCY - 1;
    localparam logic [DW-1:0] X_LAST = DW'(OUT_W - 1);
    localparam logic [DW-1:0] Y_LAST = DW'(OUT_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] x_q;
    logic [DW-1:0] y_q;
    logic [DW-1:0] x_d;
    logic [DW-1:0] y_d;

    // Delay line carrying {valid, y, x} alongside the outstanding reads.
    logic          vld_p [READ_LATENCY];
    logic [DW-1:0] y_p   [READ_LATENCY];
    logic [DW-1:0] x_p   [READ_LATENCY];

    // Last written values, held on the write port between writes.
    logic [DW-1:0] wr_data_q;
    logic [DW-1:0] wr_y_q;
    logic [DW-1:0] wr_x_q;

    logic adv;
    logic issue;
    logic wr_fire;
    logic any_vld;

    // A cycle only makes progress when neither frozen nor aborted; gating
    // with flush keeps the abort cycle itself free of reads and writes.
    assign adv     = !stall && !flush;
    assign issue   = (state_q == RUN) && adv;
    assign wr_fire = vld_p[LAST] && adv;

    // Pipeline occupancy, used to decide when DRAIN is finished.
    always_comb begin
        any_vld = 1'b0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            any_vld = any_vld | vld_p[k];
        end
    end

    // State and raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Next-state, counter advance and done pulse.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done    = 1'b0;
        if (flush) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                // Final pixel issued: park the counters at
                                // the origin and wait for the tail writes.
                                y_d     = '0;
                                state_d = DRAIN;
                            end else begin
                                y_d = y_q + DW'(1);
                            end
                        end else begin
                            x_d = x_q + DW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!stall && !any_vld) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Read-side delay line; frozen by stall, emptied by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
                y_p[k]   <= '0;
                x_p[k]   <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else if (!stall) begin
            vld_p[0] <= issue;
            y_p[0]   <= y_q;
            x_p[0]   <= x_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                y_p[k]   <= y_p[k-1];
                x_p[k]   <= x_p[k-1];
            end
        end
    end

    // Capture the pixel and coordinates of each completed write so the
    // write port holds steady while no write is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q <= '0;
            wr_y_q    <= '0;
            wr_x_q    <= '0;
        end else if (wr_fire) begin
            wr_data_q <= rd_data;
            wr_y_q    <= y_p[LAST];
            wr_x_q    <= x_p[LAST];
        end
    end

    // The read address follows the counters directly, so it naturally holds
    // through a stall and the buffer keeps presenting the same pixel.
    assign busy            = (state_q != IDLE);
    assign rd_ren          = issue;
    assign rd_ctrl_vars[0] = '0;
    assign rd_ctrl_vars[1] = y_q;
    assign rd_ctrl_vars[2] = x_q;

    // Write port: live data in the write cycle, held values otherwise.
    assign wr_wen          = wr_fire;
    assign wr_ctrl_vars[0] = '0;
    assign wr_ctrl_vars[1] = wr_fire ? y_p[LAST] : wr_y_q;
    assign wr_ctrl_vars[2] = wr_fire ? x_p[LAST] : wr_x_q;
    assign wr_data         = wr_fire ? rd_data   : wr_data_q;

`ifdef NN_CTRL_PROTOCOL_CHECK_EN
    logic err_q;

    // Sticky misuse flag: start while already running, or stall while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if ((start && (state_q != IDLE)) || (stall && (state_q == IDLE))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    // Every issued read must address a pixel inside the output frame.
    a_rd_in_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        rd_ren |-> ((32'(rd_ctrl_vars[2]) < 32'(OUT_W)) && (32'(rd_ctrl_vars[1]) < 32'(OUT_H)))
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nearest_neighbor_compute_ctrl.sv
// Bench for nearest_neighbor_compute_ctrl: a 4x2 frame at read latency 1
// (instance a) and read latency 3 (instance b). Each instance has a small
// buffer model returning {y[7:0], x[7:0]} for the address read.

module tb_nearest_neighbor_compute_ctrl;

    localparam int DW = 16;

`ifdef NN_CTRL_PROTOCOL_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    logic                a_flush = 1'b0, a_start = 1'b0, a_stall = 1'b0;
    logic                a_busy, a_done, a_rd_ren, a_wr_wen, a_err;
    logic [2:0][DW-1:0]  a_rd_cv, a_wr_cv;
    logic [DW-1:0]       a_rd_data = '0;
    logic [DW-1:0]       a_wr_data;

    logic                b_flush = 1'b0, b_start = 1'b0, b_stall = 1'b0;
    logic                b_busy, b_done, b_rd_ren, b_wr_wen, b_err;
    logic [2:0][DW-1:0]  b_rd_cv, b_wr_cv;
    logic [DW-1:0]       b_s0 = '0, b_s1 = '0, b_s2 = '0;
    logic [DW-1:0]       b_wr_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [63:0] a_q[$];
    logic [63:0] b_q[$];
    int          b_rdq[$];

    int a_nwr = 0, a_ndone = 0, a_first_rd = 0, a_first_wr = 0, a_last_wr = 0, a_done_cyc = 0;
    int b_nwr = 0, b_ndone = 0, b_last_rd = 0, b_last_wr = 0, b_done_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nearest_neighbor_compute_ctrl #(
        .OUT_W(4), .OUT_H(2), .READ_LATENCY(1), .DW(DW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .start(a_start), .stall(a_stall),
        .busy(a_busy), .done(a_done), .rd_ren(a_rd_ren), .rd_ctrl_vars(a_rd_cv),
        .rd_data(a_rd_data), .wr_wen(a_wr_wen), .wr_ctrl_vars(a_wr_cv),
        .wr_data(a_wr_data), .err(a_err)
    );

    nearest_neighbor_compute_ctrl #(
        .OUT_W(4), .OUT_H(2), .READ_LATENCY(3), .DW(DW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .start(b_start), .stall(b_stall),
        .busy(b_busy), .done(b_done), .rd_ren(b_rd_ren), .rd_ctrl_vars(b_rd_cv),
        .rd_data(b_s2), .wr_wen(b_wr_wen), .wr_ctrl_vars(b_wr_cv),
        .wr_data(b_wr_data), .err(b_err)
    );

    // Latency-1 buffer: output register loads only on a read.
    always @(posedge clk) if (a_rd_ren) a_rd_data <= {a_rd_cv[1][7:0], a_rd_cv[2][7:0]};

    // Latency-3 buffer: read register followed by two delay stages.
    always @(posedge clk) begin
        if (b_rd_ren) b_s0 <= {b_rd_cv[1][7:0], b_rd_cv[2][7:0]};
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_of(input int y, input int x);
        return {16'd0, 16'(y), 16'(x), 8'(y), 8'(x)};
    endfunction

    // Monitor a: pop and compare each write, record event cycles.
    always @(negedge clk) begin
        logic [63:0] e;
        if (a_rd_ren && a_rd_cv[1] == 0 && a_rd_cv[2] == 0) a_first_rd = cyc;
        if (a_wr_wen) begin
            a_nwr++;
            a_last_wr = cyc;
            if (a_wr_cv[1] == 0 && a_wr_cv[2] == 0) a_first_wr = cyc;
            if (a_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL a_unexpected_write: got y=%0d x=%0d data=%0h, required no write",
                         a_wr_cv[1], a_wr_cv[2], a_wr_data);
            end else begin
                e = a_q.pop_front();
                chk("a_write", {a_wr_cv[0], a_wr_cv[1], a_wr_cv[2], a_wr_data}, e);
            end
        end
        if (a_done) begin
            a_ndone++;
            a_done_cyc = cyc;
        end
    end

    // Monitor b: data, coordinates and read-to-write latency.
    always @(negedge clk) begin
        logic [63:0] e;
        int rc;
        if (b_rd_ren) begin
            b_rdq.push_back(cyc);
            b_last_rd = cyc;
        end
        if (b_wr_wen) begin
            b_nwr++;
            b_last_wr = cyc;
            if (b_q.size() == 0 || b_rdq.size() == 0) begin
                chk_cnt++;
                $display("FAIL b_unexpected_write: got y=%0d x=%0d, required no write",
                         b_wr_cv[1], b_wr_cv[2]);
            end else begin
                e  = b_q.pop_front();
                rc = b_rdq.pop_front();
                chk("b_write", {b_wr_cv[0], b_wr_cv[1], b_wr_cv[2], b_wr_data}, e);
                chk("b_wr_latency", 64'(cyc - rc), 64'(3));
            end
        end
        if (b_done) begin
            b_ndone++;
            b_done_cyc = cyc;
        end
    end

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) a_q.push_back(exp_of(i / 4, i % 4));
    endtask

    task automatic start_a();
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int base, input string name);
        for (int k = 0; k < 60 && a_ndone == base; k++) @(posedge clk);
        if (a_ndone == base) begin
            chk_cnt++;
            $display("FAIL %s_timeout: got no done in 60 cycles, required done", name);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int nd, nw;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_rd_ren", a_rd_ren, 0);
        chk("rst_wr_wen", a_wr_wen, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rd_cv", a_rd_cv, 0);
        chk("rst_wr_cv", a_wr_cv, 0);
        chk("rst_wr_data", a_wr_data, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_busy", b_busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Unstalled run
        nd = a_ndone; nw = a_nwr;
        push_a(8);
        start_a();
        wait_a_done(nd, "run1");
        chk("run1_writes", 64'(a_nwr - nw), 64'(8));
        chk("run1_first_wr_lag", 64'(a_first_wr - a_first_rd), 64'(1));
        chk("run1_done_after_last_wr", 64'(a_done_cyc - a_last_wr), 64'(1));
        chk("run1_done_pulses", 64'(a_ndone - nd), 64'(1));
        chk("run1_length", 64'(a_done_cyc - a_first_rd), 64'(9));
        chk("run1_idle", a_busy, 0);
        chk("run1_queue_empty", 64'(a_q.size()), 64'(0));

        // Stall for 3 cycles at the 3rd read, start while busy
        nd = a_ndone; nw = a_nwr;
        push_a(8);
        start_a();
        @(posedge clk);
        @(posedge clk); #1 a_stall = 1'b1;
        #1;
        chk("stall_rd_ren", a_rd_ren, 0);
        chk("stall_rd_addr", {a_rd_cv[1], a_rd_cv[2]}, {16'd0, 16'd2});
        chk("stall_wr_wen", a_wr_wen, 0);
        repeat (3) @(posedge clk);
        #1 a_stall = 1'b0;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        wait_a_done(nd, "run2");
        chk("run2_writes", 64'(a_nwr - nw), 64'(8));
        chk("run2_length", 64'(a_done_cyc - a_first_rd), 64'(12));
        chk("run2_done_pulses", 64'(a_ndone - nd), 64'(1));
        chk("run2_queue_empty", 64'(a_q.size()), 64'(0));
        chk("run2_err_after_busy_start", a_err, CHK_EN);

        // Flush after the 5th read
        nd = a_ndone; nw = a_nwr;
        push_a(4);
        start_a();
        repeat (5) @(posedge clk);
        #1 a_flush = 1'b1;
        @(posedge clk); #1 a_flush = 1'b0;
        chk("flush_busy", a_busy, 0);
        chk("flush_err_cleared", a_err, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_writes", 64'(a_nwr - nw), 64'(4));
        chk("flush_no_done", 64'(a_ndone - nd), 64'(0));
        chk("flush_queue_empty", 64'(a_q.size()), 64'(0));

        // Restart after flush
        nd = a_ndone; nw = a_nwr;
        push_a(8);
        start_a();
        wait_a_done(nd, "run3");
        chk("run3_writes", 64'(a_nwr - nw), 64'(8));
        chk("run3_done_pulses", 64'(a_ndone - nd), 64'(1));

        // Asynchronous reset mid-run
        nw = a_nwr;
        push_a(1);
        start_a();
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_rd_ren", a_rd_ren, 0);
        chk("arst_wr_wen", a_wr_wen, 0);
        chk("arst_rd_cv", a_rd_cv, 0);
        chk("arst_wr_cv", a_wr_cv, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_stays_idle", a_busy, 0);
        chk("arst_writes", 64'(a_nwr - nw), 64'(1));
        nd = a_ndone; nw = a_nwr;
        push_a(8);
        start_a();
        wait_a_done(nd, "run4");
        chk("run4_writes", 64'(a_nwr - nw), 64'(8));

        // Read latency 3
        nd = b_ndone; nw = b_nwr;
        for (int i = 0; i < 8; i++) b_q.push_back(exp_of(i / 4, i % 4));
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int k = 0; k < 60 && b_ndone == nd; k++) @(posedge clk);
        if (b_ndone == nd) begin
            chk_cnt++;
            $display("FAIL b_run_timeout: got no done in 60 cycles, required done");
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b_writes", 64'(b_nwr - nw), 64'(8));
        chk("b_done_after_last_rd", 64'(b_done_cyc - b_last_rd), 64'(4));
        chk("b_done_after_last_wr", 64'(b_done_cyc - b_last_wr), 64'(1));
        chk("b_done_pulses", 64'(b_ndone - nd), 64'(1));
        chk("b_queue_empty", 64'(b_q.size()), 64'(0));
        chk("b_idle", b_busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
